// File: rtl/mfp_ahb_lite_pkg.sv
// Shared AHB-Lite encodings for the parametrised interconnect.
// Holds transfer/response codes, address width and default-slave states.
package mfp_ahb_lite_pkg;

    localparam int MFP_AHB_PHYS_ADDR_BITS = 29;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

endpackage

// File: rtl/mfp_ahb_lite_default_slave.sv
// Default slave: two-cycle ERROR response for unmapped active transfers,
// plus capture of the offending address and a saturating error counter.
module mfp_ahb_lite_default_slave
    import mfp_ahb_lite_pkg::*;
#(
    parameter int ERR_CNT_BITS = 16
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HREADY,
    input  logic [31:0]             HADDR,
    input  logic                    HWRITE,
    input  logic                    unmapped,
    input  logic                    active,
    output logic                    ready,
    output logic                    resp,
    output logic [ERR_CNT_BITS-1:0] ERR_COUNT,
    output logic [31:0]             ERR_ADDR,
    output logic                    ERR_WRITE
);

    ds_state_t state, next;
    logic      start;
    logic      capture;

    assign start   = HREADY && unmapped && active;
    assign capture = (next == DS_ERR1) && (state != DS_ERR1);

    always_ff @(posedge HCLK) begin
        if (HRESET) state <= DS_IDLE;
        else        state <= next;
    end

    always_comb begin
        next  = state;
        ready = 1'b1;
        resp  = HRESP_OKAY;
        unique case (state)
            DS_IDLE: begin
                if (start) next = DS_ERR1;
            end
            DS_ERR1: begin
                ready = 1'b0;
                resp  = HRESP_ERROR;
                next  = DS_ERR2;
            end
            DS_ERR2: begin
                resp = HRESP_ERROR;
                next = start ? DS_ERR1 : DS_IDLE;
            end
            default: next = DS_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ERR_COUNT <= '0;
            ERR_ADDR  <= '0;
            ERR_WRITE <= 1'b0;
        end else if (capture) begin
            ERR_ADDR  <= HADDR;
            ERR_WRITE <= HWRITE;
            if (ERR_COUNT != '1) ERR_COUNT <= ERR_COUNT + 1'b1;
        end
    end

endmodule

// File: rtl/mfp_ahb_lite_param_interconnect.sv
// Single-master AHB-Lite interconnect: base/mask decode, registered
// data-phase select and per-slave response mux with a default slave.
module mfp_ahb_lite_param_interconnect
    import mfp_ahb_lite_pkg::*;
#(
    parameter int N_SLAVES = 5,
    parameter logic [N_SLAVES*MFP_AHB_PHYS_ADDR_BITS-1:0] SLAVE_BASE =
        {N_SLAVES{29'h0}},
    parameter logic [N_SLAVES*MFP_AHB_PHYS_ADDR_BITS-1:0] SLAVE_MASK =
        {N_SLAVES{29'h0}},
    parameter bit GATE_HSEL    = 1'b1,
    parameter int ERR_CNT_BITS = 16
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    output logic                    HREADY,
    output logic [31:0]             HRDATA,
    output logic                    HRESP,
    output logic [N_SLAVES-1:0]     HSEL_S,
    input  logic [N_SLAVES*32-1:0]  HRDATA_S,
    input  logic [N_SLAVES-1:0]     HREADYOUT_S,
    input  logic [N_SLAVES-1:0]     HRESP_S,
    output logic [ERR_CNT_BITS-1:0] ERR_COUNT,
    output logic [31:0]             ERR_ADDR,
    output logic                    ERR_WRITE
);

    localparam int AW = MFP_AHB_PHYS_ADDR_BITS;

    logic [AW-1:0]       addr;
    logic [N_SLAVES-1:0] dec;
    logic                dec_def;
    logic [N_SLAVES:0]   sel_r;
    logic                ds_ready;
    logic                ds_resp;
    logic                unused_bits;

    assign addr        = HADDR[AW-1:0];
    assign unused_bits = ^{HADDR[31:AW], HTRANS[0]};

    // First match wins, so overlapping windows resolve to the lowest index.
    always_comb begin
        dec     = '0;
        dec_def = 1'b1;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (dec_def &&
                ((addr & SLAVE_MASK[AW*i +: AW]) ==
                 (SLAVE_BASE[AW*i +: AW] & SLAVE_MASK[AW*i +: AW]))) begin
                dec[i]  = 1'b1;
                dec_def = 1'b0;
            end
        end
    end

    assign HSEL_S = (GATE_HSEL && !HREADY) ? '0 : dec;

    always_ff @(posedge HCLK) begin
        if (HRESET)      sel_r <= '0;
        else if (HREADY) sel_r <= {dec_def, dec};
    end

    always_comb begin
        HREADY = 1'b1;
        HRDATA = '0;
        HRESP  = HRESP_OKAY;
        if (sel_r[N_SLAVES]) begin
            HREADY = ds_ready;
            HRESP  = ds_resp;
        end
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_r[i]) begin
                HREADY = HREADYOUT_S[i];
                HRDATA = HRDATA_S[32*i +: 32];
                HRESP  = HRESP_S[i];
            end
        end
    end

    mfp_ahb_lite_default_slave #(
        .ERR_CNT_BITS(ERR_CNT_BITS)
    ) u_default_slave (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HREADY    (HREADY),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .unmapped  (dec_def),
        .active    (HTRANS[1]),
        .ready     (ds_ready),
        .resp      (ds_resp),
        .ERR_COUNT (ERR_COUNT),
        .ERR_ADDR  (ERR_ADDR),
        .ERR_WRITE (ERR_WRITE)
    );

endmodule

// File: doc/mfp_ahb_lite_param_interconnect.md
Name: mfp_ahb_lite_param_interconnect

Overview:
Parametrised AHB-Lite single-master interconnect that replaces the fixed five-device matrix. It decodes HADDR against per-slave base/mask pairs and registers the data-phase selection. Master-side HREADY, HRDATA and HRESP are muxed from the selected slave only; slaves are not AND-combined. Unmapped active transfers go to a built-in default slave that returns the two-cycle AHB ERROR response and records the offending address. It sits between the MIPS core bus and the RAM/GPIO/UART/EIC slaves.

Parameters:
N_SLAVES, 5, number of attached slaves (1..16).
SLAVE_BASE, {N_SLAVES{29'h0}}, packed N_SLAVES*29 physical base addresses; slave i uses bits [29*i+28 : 29*i].
SLAVE_MASK, {N_SLAVES{29'h0}}, packed N_SLAVES*29 compare masks; 1 = bit is compared.
GATE_HSEL, 1, 1: HSEL_S is gated with master HREADY (legacy slave compatibility); 0: HSEL_S is raw decode.
ERR_CNT_BITS, 16, width of the unmapped-access counter.

Ports:
HCLK  in  1  bus clock
HRESET  in  1  synchronous reset, active-high
HADDR  in  32  master address
HTRANS  in  2  master transfer type
HWRITE  in  1  master write flag
HREADY  out  1  master ready; also broadcast to slaves
HRDATA  out  32  master read data
HRESP  out  1  master response
HSEL_S  out  N_SLAVES  per-slave select
HRDATA_S  in  N_SLAVES*32  packed slave read data
HREADYOUT_S  in  N_SLAVES  per-slave ready
HRESP_S  in  N_SLAVES  per-slave response
ERR_COUNT  out  ERR_CNT_BITS  saturating count of unmapped active transfers
ERR_ADDR  out  32  HADDR of the most recent unmapped active transfer
ERR_WRITE  out  1  HWRITE of that transfer

Behaviour:
- Decode (combinational): match[i] = ((HADDR[28:0] & MASK_i) == (BASE_i & MASK_i)). The lowest matching index wins (one-hot dec). No match selects the default slave (dec_def = 1).
- HSEL_S = GATE_HSEL ? (HREADY ? dec : 0) : dec.
- Data-phase select sel_r, N_SLAVES+1 bits one-hot including the default slave: loaded from {dec_def, dec} on every cycle with HREADY = 1, held otherwise. Reset value is all-zero ("none").
- Output mux by sel_r:
  - Slave i: HREADY = HREADYOUT_S[i], HRDATA = slice i, HRESP = HRESP_S[i].
  - Default slave: FSM outputs, HRDATA = 0.
  - None: HREADY = 1, HRDATA = 0, HRESP = 0.
  - Other slaves' HREADYOUT has no effect.
- Default-slave FSM states: IDLE, ERR1, ERR2. Reset state is IDLE.
  - IDLE: drives HREADY = 1, HRESP = 0. Goes to ERR1 when HREADY && dec_def && HTRANS[1] (NONSEQ/SEQ).
  - ERR1: drives HREADY = 0, HRESP = 1. Always goes to ERR2.
  - ERR2: drives HREADY = 1, HRESP = 1. Goes to ERR1 if the same unmapped-active condition holds (back-to-back error); otherwise IDLE.
  - Unmapped IDLE/BUSY transfers get a zero-wait OKAY, because the FSM stays in IDLE.
- Error capture: on the cycle the FSM is entered into ERR1, ERR_ADDR <= HADDR and ERR_WRITE <= HWRITE. ERR_COUNT increments and saturates at all-ones.
- Latency: a mapped transfer adds zero wait states beyond the slave's own. An unmapped active transfer costs exactly 2 data-phase cycles.
- Simultaneous events: an address phase accepted in ERR2 or in a slave's last ready cycle switches sel_r on that same edge.
- Reset mid-transfer: on the next edge sel_r goes to none, the FSM to IDLE, and ERR_COUNT/ERR_ADDR/ERR_WRITE to 0. HREADY is 1 the cycle after reset.
- Overlapping base/mask windows are legal; the lowest index wins.

Decomposition:
- Package mfp_ahb_lite_pkg holds:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ)
  - HRESP_OKAY/ERROR
  - MFP_AHB_PHYS_ADDR_BITS = 29
  - default-slave state encodings
- Sub-module mfp_ahb_lite_default_slave contains the FSM, the error capture registers and the counter.

Test Plan:
- N_SLAVES = 2, slave0 base 0x1fc00000 mask 0x1fc00000, slave1 base 0 mask 0x1c000000. Read 0x1fc00010 -> HSEL_S = 01; next cycle HRDATA = slave0 data, HRESP = 0.
- Slave1 holds HREADYOUT low for 3 cycles while slave0 HREADYOUT = 0 is idle -> master HREADY tracks only slave1 and stalls exactly 3 cycles; slave0's ready state is ignored.
- NONSEQ to 0x10400000 (unmapped) -> data phase HREADY = 0/HRESP = 1, then HREADY = 1/HRESP = 1. ERR_ADDR = 0x10400000, ERR_COUNT = 1.
- Two back-to-back unmapped NONSEQ, the second issued in ERR2 -> ERR1, ERR2, ERR1, ERR2. ERR_COUNT = 2.
- Unmapped HTRANS = IDLE -> HREADY = 1, HRESP = 0, ERR_COUNT unchanged.
- HRESET asserted during ERR1 -> next cycle HREADY = 1, HRESP = 0, ERR_COUNT = 0. With ERR_CNT_BITS = 2, five errors give ERR_COUNT = 3 (saturation).
